gate_func_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit three-input gate network y = (a | b) ^ (~b & c).
- Applies one of four selectable three-input bitwise functions across WIDTH-bit operand vectors.
- Registers the result through a 2-stage valid/ready pipeline with full backpressure.
- Keeps a saturating count of delivered results.
- Sits between an operand producer and a result consumer in the gate-level datapath.

---
 rtl/gate_pkg.sv | 22 ++
 rtl/gate_func_stage.sv | 33 +++
 rtl/gate_func_pipe.sv | 107 ++++++++++
 tb/tb_gate_func_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared mode encodings, default widths and the stage-2 combine-op helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_pkg;

    localparam int GATE_WIDTH = 8;
    localparam int GATE_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_XOR_OR = 2'd0,
        MODE_MUX    = 2'd1,
        MODE_MAJ    = 2'd2,
        MODE_PAR    = 2'd3
    } mode_e;

    // Each mode is split into two stage-1 terms. XOR_OR and PAR merge them
    // with XOR in stage 2. MUX and MAJ merge them with OR.
    function automatic logic combine_is_xor(input mode_e m);
        return (m == MODE_XOR_OR) || (m == MODE_PAR);
    endfunction

endpackage

// File: rtl/gate_func_stage.sv
// Generic pipeline register slice: one valid bit plus a W-bit payload.
// Latency: 1 cycle from an accepted input to out_valid.
// Backpressure: in_ready = !out_valid || out_ready. The slice holds while full and stalled.
module gate_func_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_dat
);

    // The slice can advance when it is empty or when its content leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    // Load a new beat on advance. The payload is kept when nothing valid arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/gate_func_pipe.sv
// Applies one of four 3-input bitwise functions to WIDTH-bit operands. It also counts delivered results, saturating at the maximum.
// Latency: 2 cycles from input transfer to out_valid. Throughput is 1 result per cycle.
// Backpressure: full valid/ready. At most 2 triples are buffered, and in_ready is combinational from state and out_ready.
module gate_func_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = GATE_WIDTH,
    parameter int CNT_W = GATE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] count
);

    // Stage-1 payload: captured mode plus the two intermediate terms.
    typedef struct packed {
        mode_e            mode;
        logic [WIDTH-1:0] t0;
        logic [WIDTH-1:0] t1;
    } terms_t;

    localparam int TERMS_W = $bits(terms_t);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    terms_t           s1_d;
    terms_t           s1_q;
    logic             s1_valid;
    logic             s2_ready;
    logic [WIDTH-1:0] y_d;

    // Split each function into two terms. Stage 2 then needs only one XOR or OR.
    always_comb begin
        s1_d.mode = mode_e'(mode);
        s1_d.t0   = '0;
        s1_d.t1   = '0;
        case (mode_e'(mode))
            MODE_XOR_OR: begin
                s1_d.t0 = a | b;
                s1_d.t1 = ~b & c;
            end
            MODE_MUX: begin
                s1_d.t0 = b & a;
                s1_d.t1 = ~b & c;
            end
            MODE_MAJ: begin
                s1_d.t0 = a & b;
                s1_d.t1 = (a | b) & c;
            end
            MODE_PAR: begin
                s1_d.t0 = a ^ b;
                s1_d.t1 = c;
            end
            default: begin
                s1_d.t0 = '0;
                s1_d.t1 = '0;
            end
        endcase
    end

    gate_func_stage #(
        .W(TERMS_W)
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dat   (s1_d),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_dat  (s1_q)
    );

    assign y_d = combine_is_xor(s1_q.mode) ? (s1_q.t0 ^ s1_q.t1)
                                           : (s1_q.t0 | s1_q.t1);

    gate_func_stage #(
        .W(WIDTH)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_dat   (y_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dat  (y)
    );

    // Count output handshakes, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_valid && out_ready && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_func_pipe.sv
module tb_gate_func_pipe;
    import gate_pkg::*;

    localparam int W = 4;
    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   mode;
    logic [W-1:0] a, b, c;
    logic         in_ready, out_valid;
    logic [W-1:0] y;
    logic [15:0]  count;
    logic         in_ready_s, out_valid_s;
    logic [W-1:0] y_s;
    logic [1:0]   count_s;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gate_func_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .c(c), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .count(count)
    );

    gate_func_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .mode(mode), .a(a), .b(b), .c(c), .out_valid(out_valid_s),
        .out_ready(out_ready), .y(y_s), .count(count_s)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] y;
    } vec_t;

    vec_t tbl [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference function built from the per-bit rules: or/xor form, select, vote count, and parity.
    function automatic logic [W-1:0] ref_y(input logic [1:0] m, input logic [W-1:0] x,
                                           input logic [W-1:0] s, input logic [W-1:0] z);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int ones;
            ones = int'(x[i]) + int'(s[i]) + int'(z[i]);
            case (m)
                2'd0:    r[i] = (x[i] | s[i]) ^ (!s[i] & z[i]);
                2'd1:    r[i] = s[i] ? x[i] : z[i];
                2'd2:    r[i] = (ones >= 2);
                default: r[i] = (ones % 2) == 1;
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [W-1:0] x,
                         input logic [W-1:0] s, input logic [W-1:0] z);
        in_valid = 1'b1;
        mode = m;
        a = x;
        b = s;
        c = z;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] bp_y[3];
        logic [W-1:0] exp_y;
        logic [W-1:0] hold_y;
        logic         hold_pend;
        int           delivered;
        int           seen;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 2'd0;
        a = '0;
        b = '0;
        c = '0;
        step();
        step();
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_count", count, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_count_sat", count_s, 0);
        rst_n = 1'b1;

        tbl[0] = '{MODE_XOR_OR, 4'b1100, 4'b1010, 4'b0110, 4'b1010};
        tbl[1] = '{MODE_MUX,    4'b1100, 4'b1010, 4'b0110, 4'b1100};
        tbl[2] = '{MODE_MAJ,    4'b1100, 4'b1010, 4'b0110, 4'b1110};
        tbl[3] = '{MODE_PAR,    4'b1100, 4'b1010, 4'b0110, 4'b0000};
        tbl[4] = '{MODE_XOR_OR, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
        tbl[5] = '{MODE_MUX,    4'b0101, 4'b0000, 4'b0011, 4'b0011};
        tbl[6] = '{MODE_MAJ,    4'b1111, 4'b0000, 4'b0000, 4'b0000};
        tbl[7] = '{MODE_PAR,    4'b1111, 4'b1111, 4'b1111, 4'b1111};
        tbl[8] = '{MODE_MAJ,    4'b1010, 4'b0110, 4'b0011, 4'b0010};

        // Back-to-back stream with the mode changing every beat, no backpressure.
        for (int i = 0; i <= N; i++) begin
            if (i < N) drive(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c);
            else in_valid = 1'b0;
            #1;
            check("tbl_in_ready", in_ready, 1);
            step();
            if (i == 0) begin
                check("tbl_latency_not_early", out_valid, 0);
            end else begin
                check("tbl_out_valid", out_valid, 1);
                check($sformatf("tbl_y[%0d]", i - 1), y, tbl[i - 1].y);
                check("tbl_count", count, i - 1);
            end
        end
        step();
        check("tbl_drained", out_valid, 0);
        check("tbl_count_final", count, N);
        check("sat_count_holds_3", count_s, 3);

        // Backpressure: three triples are offered while the consumer is stalled.
        bp_y[0] = ref_y(2'd0, 4'b0011, 4'b0101, 4'b1001);
        bp_y[1] = ref_y(2'd2, 4'b0110, 4'b1100, 4'b1011);
        bp_y[2] = ref_y(2'd3, 4'b1110, 4'b0100, 4'b0001);
        out_ready = 1'b0;
        drive(2'd0, 4'b0011, 4'b0101, 4'b1001);
        #1; check("bp_accept0", in_ready, 1);
        step();
        drive(2'd2, 4'b0110, 4'b1100, 4'b1011);
        #1; check("bp_accept1", in_ready, 1);
        step();
        drive(2'd3, 4'b1110, 4'b0100, 4'b0001);
        #1; check("bp_in_ready_low", in_ready, 0);
        step();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_y0", y, bp_y[0]);
        step();
        check("bp_hold_y0_again", y, bp_y[0]);
        check("bp_still_blocked", in_ready, 0);
        out_ready = 1'b1;
        #1; check("bp_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_y1", y, bp_y[1]);
        step();
        check("bp_y2", y, bp_y[2]);
        check("bp_y2_valid", out_valid, 1);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_count", count, N + 3);

        // Reset with both stages full: the in-flight results must disappear.
        out_ready = 1'b0;
        drive(2'd1, 4'b1111, 4'b1111, 4'b0000);
        step();
        drive(2'd0, 4'b1111, 4'b0000, 4'b1111);
        step();
        in_valid = 1'b0;
        #1; check("rst_pre_full", in_ready, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count_sat", count_s, 0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("rst_flushed", seen, 0);

        // Random traffic compared with a queue model.
        delivered = 0;
        hold_pend = 1'b0;
        hold_y = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode = 2'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            c = W'($urandom);
            #1;
            if (hold_pend) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_valid_sat", out_valid_s, 1);
                check("rnd_hold_y", y, hold_y);
            end
            check("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
            check("rnd_in_ready_sat", in_ready_s, (q.size() < 2) || out_ready);
            if (out_valid) check("rnd_valid_has_data", q.size() != 0, 1);
            if (out_valid && out_ready && q.size() != 0) begin
                exp_y = q.pop_front();
                check("rnd_y", y, exp_y);
                check("rnd_y_sat", y_s, exp_y);
                delivered++;
            end
            if (in_valid && in_ready) q.push_back(ref_y(mode, a, b, c));
            hold_pend = out_valid && !out_ready;
            hold_y = y;
            step();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                exp_y = q.pop_front();
                check("drain_y", y, exp_y);
                delivered++;
            end
            step();
        end
        check("drain_empty", q.size(), 0);
        check("drain_no_extra", out_valid, 0);
        check("rnd_count", count, delivered);
        check("rnd_count_sat", count_s, (delivered > 3) ? 3 : delivered);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
